// File: rtl/axppa_error_monitor.sv
// axppa_error_monitor: compares exact and approximate adder sums over a
// window of WINDOW samples. It accumulates the error count, the summed error
// distance and (optionally) the maximum error distance, then hands the
// results over through a valid/ack handshake.
// Optional feature macro: AXPPA_MON_MAX_ED_EN (defined = max_ed tracked,
// undefined = max_ed tied to 0).
module axppa_error_monitor #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SUM_W  = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH:0]     exact_sum,
  input  logic [WIDTH:0]     approx_sum,
  output logic               res_valid,
  input  logic               res_ack,
  output logic [CNT_W-1:0]   err_count,
  output logic [SUM_W-1:0]   ed_sum,
  output logic [WIDTH:0]     max_ed,
  output logic               busy
);

  localparam int unsigned SW    = WIDTH + 1;
  localparam int unsigned DW    = WIDTH + 2;
  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  // Sample counter must be able to reach WINDOW even when CNT_W is small.
  localparam int unsigned SMP_W = (WIN_W > CNT_W) ? WIN_W : CNT_W;
  localparam logic [SMP_W-1:0] WIN_LAST = SMP_W'(WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic               drain_q, drain_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic               clr;
  logic               xfer;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_ne_q, s1_ne_d;
  logic [SW-1:0]      s1_ed_q, s1_ed_d;
  logic signed [DW-1:0] diff;

  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [SUM_W-1:0]   ed_sum_q, ed_sum_d;
  logic [SUM_W:0]     sum_ext;

  assign xfer = in_valid & in_ready_q;

  // Window control: next state, sample counter and registered handshake flags.
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    drain_d   = drain_q;
    clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          smp_cnt_d = '0;
          clr       = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          smp_cnt_d = smp_cnt_q + SMP_W'(1);
          if (smp_cnt_q + SMP_W'(1) == WIN_LAST) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_RUN);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Stage 1: error distance and mismatch flag of the accepted pair.
  always_comb begin
    diff       = $signed({1'b0, exact_sum}) - $signed({1'b0, approx_sum});
    s1_valid_d = xfer;
    s1_ne_d    = (exact_sum != approx_sum);
    s1_ed_d    = diff[DW-1] ? SW'(-diff) : SW'(diff);
  end

  // Stage 2: saturating accumulation of count and summed distance.
  always_comb begin
    err_count_d = err_count_q;
    ed_sum_d    = ed_sum_q;
    sum_ext     = {1'b0, ed_sum_q} + (SUM_W + 1)'(s1_ed_q);
    if (clr) begin
      err_count_d = '0;
      ed_sum_d    = '0;
    end else if (s1_valid_q) begin
      if (s1_ne_q && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      ed_sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    end
  end

  // State, pipeline and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      drain_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_ne_q     <= 1'b0;
      s1_ed_q     <= '0;
      err_count_q <= '0;
      ed_sum_q    <= '0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      s1_valid_q  <= s1_valid_d;
      s1_ne_q     <= s1_ne_d;
      s1_ed_q     <= s1_ed_d;
      err_count_q <= err_count_d;
      ed_sum_q    <= ed_sum_d;
    end
  end

`ifdef AXPPA_MON_MAX_ED_EN
  logic [SW-1:0] max_ed_q, max_ed_d;

  // Running maximum of the error distance.
  always_comb begin
    max_ed_d = max_ed_q;
    if (clr) begin
      max_ed_d = '0;
    end else if (s1_valid_q && (s1_ed_q > max_ed_q)) begin
      max_ed_d = s1_ed_q;
    end
  end

  // Maximum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_ed_q <= '0;
    end else begin
      max_ed_q <= max_ed_d;
    end
  end

  assign max_ed = max_ed_q;
`else
  assign max_ed = '0;
`endif

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign err_count = err_count_q;
  assign ed_sum    = ed_sum_q;

endmodule
